tt_sweep_extractor: RTL and testbench
=====================================

Name: tt_sweep_extractor

Overview:
- Sequential truth-table reader for 7-input single-output functions, e.g. majority-gate networks.
- Drives all 128 input minterms in order onto an external function under test (FUT) and captures its response into a 128-bit truth table.
- Reports onset count and compares the captured table against an expected table.
- Used as the characterisation/verification end for classified 7-input functions.

Parameters:
FN_LATENCY, 0, cycles from x_out changing to the matching fn_in being valid (0 = combinational FUT; legal 0..7)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
start  input  1  begin a sweep; sampled only in IDLE
exp_tt  input  128  expected truth table; sampled on the accepted start cycle
fn_in  input  1  FUT output for the minterm issued FN_LATENCY cycles earlier
x_out  output  7  minterm driven to FUT; x_out[0]=x0 … x_out[6]=x6
busy  output  1  high from the cycle after accepted start through the done cycle
done  output  1  one-cycle pulse when results are final
tt  output  128  captured table; tt[i] = f(x) where i = x_out value
onset_count  output  8  number of 1s in tt (0..128)
match  output  1  tt == sampled exp_tt; valid from done onward
first_mismatch  output  7  lowest index i with tt[i] != exp_tt[i]; 0 when match=1

Behaviour:
- Reset values: state IDLE, x_out=0, busy=0, done=0, tt=0, onset_count=0, match=0, first_mismatch=0.
- Reset has priority over every other event in any state. Reset mid-sweep abandons the sweep and clears all results. No done pulse follows.
- State IDLE:
  - start=1 → SWEEP. Latch exp_tt; clear tt, onset_count, match, first_mismatch; issue index 0 on x_out in the next cycle.
- State SWEEP:
  - x_out increments by 1 each cycle, 0..127, one minterm per cycle, no stalls.
  - After 127 is issued, x_out holds 127 → DRAIN.
- Capture pipeline:
  - A FN_LATENCY-deep delay line carries {valid, index} for each issued minterm.
  - When a delayed entry is valid, tt[index] ← fn_in and onset_count += fn_in.
  - Compare per captured bit: the first capture with fn_in != exp_tt[index] records first_mismatch=index and sets a mismatch flag. Later mismatches do not overwrite it.
  - With FN_LATENCY=0, the capture happens in the same cycle the index is on x_out.
- State DRAIN:
  - Waits until the index-127 capture has occurred (FN_LATENCY cycles), then → DONE.
  - With FN_LATENCY=0, DRAIN lasts 0 cycles.
- State DONE:
  - One cycle. done=1; match=!mismatch flag; → IDLE.
- Timing: start accepted in cycle 0 → index i on x_out in cycle 1+i → done in cycle 129+FN_LATENCY. busy is high in cycles 1..129+FN_LATENCY.
- start while busy is ignored and not queued. start asserted in the same cycle as done is ignored. start in the cycle after done is accepted.
- Back-to-back sweeps clear the previous results at the accepted start.
- tt, onset_count and match remain stable in IDLE until the next accepted start or reset.
- onset_count saturation is not needed: maximum 128 fits in 8 bits.
- fn_in is ignored when no valid capture entry is present, so X on fn_in outside capture slots has no effect.

Test Plan:
- Golden function, FN_LATENCY=0:
  - FUT = MAJ(x1, MAJ(x0,x3,x4), MAJ(x0,x2,MAJ(x5,x6,MAJ(x0,x1,x3)))), exp_tt = 128'hfeeaeac8eea8ea88eea8ea88eca8a880.
  - Required: tt equals that constant, onset_count=64, match=1, first_mismatch=0, done in cycle 129.
- Latency: same FUT behind a 3-stage register pipe, FN_LATENCY=3.
  - Required: identical tt, done in cycle 132, busy high cycles 1..132, x_out holds 127 during DRAIN.
- Mismatch: golden FUT, exp_tt = constant XOR (1<<5) | (1<<90).
  - Required: match=0, first_mismatch=5, tt unchanged (bit 5 = 0).
- Constant FUTs:
  - fn_in=1 → tt=all ones, onset_count=128.
  - fn_in=0 → tt=0, onset_count=0.
  - With exp_tt=0, the fn_in=1 run must give first_mismatch=0 and match=0.
- Control:
  - start pulsed at cycles 40 and 129 (the done cycle) → both ignored.
  - start at cycle 130 → new sweep accepted; outputs cleared in cycle 131.
- Reset mid-sweep:
  - reset at cycle 60 → next cycle IDLE, all outputs at reset values, no done.
  - A later start completes normally with correct tt.

Source files
------------

// File: rtl/tt_sweep_extractor_if.sv
// Sweep extractor bus: start/expected table in, minterm out to the FUT, FUT response back, results out.
// master = sequencing agent and FUT; slave = the extractor itself.
interface tt_sweep_extractor_if;
    logic         start;
    logic [127:0] exp_tt;
    logic         fn_in;
    logic [6:0]   x_out;
    logic         busy;
    logic         done;
    logic [127:0] tt;
    logic [7:0]   onset_count;
    logic         match;
    logic [6:0]   first_mismatch;

    modport master (
        output start, exp_tt, fn_in,
        input  x_out, busy, done, tt, onset_count, match, first_mismatch
    );

    modport slave (
        input  start, exp_tt, fn_in,
        output x_out, busy, done, tt, onset_count, match, first_mismatch
    );
endinterface

// File: rtl/tt_sweep_extractor.sv
// Walks all 128 minterms of a 7-input FUT and captures its truth table, onset count and expected-table compare.
// done 129+FN_LATENCY cycles after an accepted start; no backpressure, start is dropped unless idle.
module tt_sweep_extractor #(
    parameter int FN_LATENCY = 0
) (
    input  logic            clk,
    input  logic            reset,
    tt_sweep_extractor_if.slave sw
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t       state, state_nx;
    logic [127:0] exp_q;
    logic         mm_flag;
    logic         issue_vld;
    logic         cap_vld;
    logic [6:0]   cap_idx;
    logic         cap_mis;
    logic         last_cap;

    assign issue_vld = (state == SWEEP);

    // The capture slot is the issued index delayed by the FUT latency.
    generate
        if (FN_LATENCY == 0) begin : g_comb
            assign cap_vld = issue_vld;
            assign cap_idx = sw.x_out;
        end else begin : g_pipe
            logic [FN_LATENCY-1:0] dly_vld;
            logic [6:0]            dly_idx [FN_LATENCY];

            always_ff @(posedge clk) begin
                if (reset) begin
                    dly_vld <= '0;
                    for (int i = 0; i < FN_LATENCY; i++) dly_idx[i] <= '0;
                end else begin
                    dly_vld[0] <= issue_vld;
                    dly_idx[0] <= sw.x_out;
                    for (int i = 1; i < FN_LATENCY; i++) begin
                        dly_vld[i] <= dly_vld[i-1];
                        dly_idx[i] <= dly_idx[i-1];
                    end
                end
            end

            assign cap_vld = dly_vld[FN_LATENCY-1];
            assign cap_idx = dly_idx[FN_LATENCY-1];
        end
    endgenerate

    assign cap_mis  = cap_vld && (sw.fn_in != exp_q[cap_idx]);
    assign last_cap = cap_vld && (cap_idx == 7'd127);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sw.start) state_nx = SWEEP;
            // With a combinational FUT the last capture lands with the last issue, skipping DRAIN.
            SWEEP:   if (sw.x_out == 7'd127) state_nx = last_cap ? DONE : DRAIN;
            DRAIN:   if (last_cap) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q             <= '0;
            mm_flag           <= 1'b0;
            sw.x_out          <= '0;
            sw.busy           <= 1'b0;
            sw.done           <= 1'b0;
            sw.tt             <= '0;
            sw.onset_count    <= '0;
            sw.match          <= 1'b0;
            sw.first_mismatch <= '0;
        end else begin
            sw.busy <= (state_nx != IDLE);
            sw.done <= (state_nx == DONE);
            if (state == IDLE && sw.start) begin
                exp_q             <= sw.exp_tt;
                mm_flag           <= 1'b0;
                sw.x_out          <= '0;
                sw.tt             <= '0;
                sw.onset_count    <= '0;
                sw.match          <= 1'b0;
                sw.first_mismatch <= '0;
            end else begin
                if (state == SWEEP && sw.x_out != 7'd127) sw.x_out <= sw.x_out + 7'd1;
                if (cap_vld) begin
                    sw.tt[cap_idx] <= sw.fn_in;
                    sw.onset_count <= sw.onset_count + {7'd0, sw.fn_in};
                    if (cap_mis && !mm_flag) begin
                        mm_flag           <= 1'b1;
                        sw.first_mismatch <= cap_idx;
                    end
                end
                // Fold in a mismatch on the final capture, which lands on the same edge.
                if (state_nx == DONE) sw.match <= !(mm_flag || cap_mis);
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_extractor.sv
// Scoreboarded bench: one extractor with a combinational FUT, one behind a 3-stage FUT pipe.
module tb_tt_sweep_extractor;

    localparam logic [127:0] GOLD = 128'hfeeaeac8eea8ea88eea8ea88eca8a880;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tt_sweep_extractor_if if0();
    tt_sweep_extractor_if if3();

    tt_sweep_extractor #(.FN_LATENCY(0)) u_dut0 (.clk(clk), .reset(reset), .sw(if0));
    tt_sweep_extractor #(.FN_LATENCY(3)) u_dut3 (.clk(clk), .reset(reset), .sw(if3));

    int fut_mode = 0;   // 0 golden, 1 constant one, 2 constant zero

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic fut(input logic [6:0] x, input int m);
        if (m == 1) return 1'b1;
        if (m == 2) return 1'b0;
        return maj(x[1], maj(x[0], x[3], x[4]),
                   maj(x[0], x[2], maj(x[5], x[6], maj(x[0], x[1], x[3]))));
    endfunction

    assign if0.fn_in = fut(if0.x_out, fut_mode);

    logic p1, p2, p3;
    always @(posedge clk) begin
        p1 <= fut(if3.x_out, fut_mode);
        p2 <= p1;
        p3 <= p2;
    end
    assign if3.fn_in = p3;

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [127:0] tt;
        logic [7:0]   oc;
        logic         m;
        logic [6:0]   fm;
        int           dk;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    int   sc0 = 0, sc3 = 0;
    bit   en0 = 1'b0, en3 = 1'b0;

    // Called at posedge+1: the current cycle becomes cycle 0 of the sweep.
    task automatic launch(input int sel, input int mode, input logic [127:0] tt_exp,
                          input logic [127:0] exp_in);
        exp_t e;
        e.tt = tt_exp;
        e.oc = '0;
        e.fm = '0;
        for (int i = 127; i >= 0; i--) begin
            e.oc = e.oc + 8'(tt_exp[i]);
            if (tt_exp[i] != exp_in[i]) e.fm = 7'(i);
        end
        e.m  = (tt_exp == exp_in);
        e.dk = (sel == 0) ? 129 : 132;
        fut_mode = mode;
        if (sel == 0) begin
            if0.exp_tt = exp_in; if0.start = 1'b1; sc0 = cyc; en0 = 1'b1; q0.push_back(e);
        end else begin
            if3.exp_tt = exp_in; if3.start = 1'b1; sc3 = cyc; en3 = 1'b1; q3.push_back(e);
        end
        @(posedge clk); #1;
        if0.start = 1'b0;
        if3.start = 1'b0;
    endtask

    task automatic to_cycle(input int sc, input int n);
        while (cyc - sc < n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse0();
        if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((q0.size() != 0 || q3.size() != 0) && t < 400) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 400) begin
            chk("done_timeout", 128'(q0.size() + q3.size()), 128'd0);
            q0.delete();
            q3.delete();
        end
        repeat (3) begin @(posedge clk); #1; end
        en0 = 1'b0;
        en3 = 1'b0;
    endtask

    task automatic mon(input int sel, input int L, input int sc, input bit en,
                       input logic done, input logic busy, input logic [6:0] x,
                       input logic [127:0] tt, input logic [7:0] oc, input logic m,
                       input logic [6:0] fm);
        int   k = cyc - sc;
        int   xe;
        exp_t e;
        string p = $sformatf("L%0d", L);
        if (done) begin
            if ((sel == 0 && q0.size() == 0) || (sel != 0 && q3.size() == 0)) begin
                chk({p, "_unexpected_done"}, 128'(done), 128'd0);
            end else begin
                if (sel == 0) e = q0.pop_front();
                else          e = q3.pop_front();
                chk({p, "_tt"}, tt, e.tt);
                chk({p, "_onset"}, 128'(oc), 128'(e.oc));
                chk({p, "_match"}, 128'(m), 128'(e.m));
                chk({p, "_first_mismatch"}, 128'(fm), 128'(e.fm));
                chk({p, "_done_cycle"}, 128'(k), 128'(e.dk));
            end
        end
        if (en && k >= 0 && k <= 130 + L) begin
            chk({p, "_busy"}, 128'(busy), 128'(k >= 1 && k <= 129 + L));
            if (k >= 1 && k <= 129 + L) begin
                xe = (k - 1 > 127) ? 127 : k - 1;
                chk({p, "_x_out"}, 128'(x), 128'(xe));
            end
            if (k == 1) begin
                chk({p, "_clr_tt"}, tt, 128'd0);
                chk({p, "_clr_onset"}, 128'(oc), 128'd0);
                chk({p, "_clr_match"}, 128'(m), 128'd0);
                chk({p, "_clr_fm"}, 128'(fm), 128'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(0, 0, sc0, en0, if0.done, if0.busy, if0.x_out, if0.tt, if0.onset_count,
                if0.match, if0.first_mismatch);
            mon(1, 3, sc3, en3, if3.done, if3.busy, if3.x_out, if3.tt, if3.onset_count,
                if3.match, if3.first_mismatch);
        end
    end

    task automatic rst_chk(input string p, input logic [6:0] x, input logic busy,
                           input logic done, input logic [127:0] tt, input logic [7:0] oc,
                           input logic m, input logic [6:0] fm);
        chk({p, "_rst_x_out"}, 128'(x), 128'd0);
        chk({p, "_rst_busy"}, 128'(busy), 128'd0);
        chk({p, "_rst_done"}, 128'(done), 128'd0);
        chk({p, "_rst_tt"}, tt, 128'd0);
        chk({p, "_rst_onset"}, 128'(oc), 128'd0);
        chk({p, "_rst_match"}, 128'(m), 128'd0);
        chk({p, "_rst_fm"}, 128'(fm), 128'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] mis;
        logic [127:0] ones;
        mis  = GOLD ^ ((128'd1 << 5) | (128'd1 << 90));
        ones = '1;
        if0.start = 1'b0; if0.exp_tt = '0;
        if3.start = 1'b0; if3.exp_tt = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        rst_chk("L0", if0.x_out, if0.busy, if0.done, if0.tt, if0.onset_count, if0.match, if0.first_mismatch);
        rst_chk("L3", if3.x_out, if3.busy, if3.done, if3.tt, if3.onset_count, if3.match, if3.first_mismatch);
        @(posedge clk); #1;

        launch(0, 0, GOLD, GOLD); wait_drain();
        launch(1, 0, GOLD, GOLD); wait_drain();
        launch(0, 0, GOLD, mis);  wait_drain();
        launch(1, 0, GOLD, mis);  wait_drain();
        launch(0, 1, ones, '0);   wait_drain();
        launch(0, 2, '0, '0);     wait_drain();
        launch(1, 1, ones, ones); wait_drain();

        // Starts while busy and on the done cycle are dropped; the next cycle is accepted.
        launch(0, 0, GOLD, GOLD);
        to_cycle(sc0, 40);  pulse0();
        to_cycle(sc0, 129); pulse0();
        launch(0, 2, '0, GOLD);
        wait_drain();

        // Reset mid-sweep: abandon, clear, no done; a later sweep still completes.
        launch(0, 0, GOLD, GOLD);
        to_cycle(sc0, 60);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q0.delete();
        en0 = 1'b0;
        @(negedge clk);
        rst_chk("L0_mid", if0.x_out, if0.busy, if0.done, if0.tt, if0.onset_count, if0.match, if0.first_mismatch);
        repeat (150) begin @(posedge clk); #1; end
        launch(0, 0, GOLD, GOLD); wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
